// File: rtl/led_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_pkg : command codes, scan states and default timing shared by  |
// |           the LED indicator blocks.                                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package led_pkg;

    localparam logic [1:0] CMD_STOP      = 2'b00;
    localparam logic [1:0] CMD_RUN_FWD   = 2'b01;
    localparam logic [1:0] CMD_RUN_PP    = 2'b10;
    localparam logic [1:0] CMD_BLINK_ALL = 2'b11;

    localparam int unsigned LED_PERIOD_DEF   = 2_000_000;
    localparam int unsigned LED_ON_START_DEF = 500_000;
    localparam int unsigned LED_ON_END_DEF   = 1_000_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FWD   = 2'd1,
        ST_PP    = 2'd2,
        ST_BLINK = 2'd3
    } led_state_e;

    function automatic led_state_e code2state(input logic [1:0] code);
        case (code)
            CMD_RUN_FWD:   return ST_FWD;
            CMD_RUN_PP:    return ST_PP;
            CMD_BLINK_ALL: return ST_BLINK;
            default:       return ST_IDLE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_period_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_period_timer : free-running period counter with boundary flag  |
// |                    and a registered on-window flag.                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module led_period_timer #(
    parameter int unsigned PERIOD   = 2_000_000,
    parameter int unsigned ON_START = 500_000,
    parameter int unsigned ON_END   = 1_000_000,
    parameter int unsigned CW       = 21
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic En_i,
    input  logic Clr_i,
    output logic Boundary_o,
    output logic Win_o
);

    localparam logic [CW-1:0] C_PERIOD   = CW'(PERIOD);
    localparam logic [CW-1:0] C_ON_START = CW'(ON_START);
    localparam logic [CW-1:0] C_ON_END   = CW'(ON_END);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          win_q, win_d;

    assign Boundary_o = En_i && (cnt_q == C_PERIOD);
    assign Win_o      = win_q;

    always_comb begin
        cnt_d = cnt_q;
        if (Clr_i)
            cnt_d = '0;
        else if (En_i)
            cnt_d = (cnt_q == C_PERIOD) ? '0 : cnt_q + 1'b1;
        // Window flag lags the count by one cycle; forced low while stopped.
        win_d = En_i && !Clr_i && (cnt_q >= C_ON_START) && (cnt_q < C_ON_END);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q <= '0;
            win_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            win_q <= win_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_scan_ctrl : shares one on-window across N_LED outputs using     |
// |                 forward, ping-pong or all-blink scanning.          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module led_scan_ctrl
    import led_pkg::*;
#(
    parameter int unsigned N_LED        = 4,
    parameter int unsigned PERIOD       = LED_PERIOD_DEF,
    parameter int unsigned ON_START     = LED_ON_START_DEF,
    parameter int unsigned ON_END       = LED_ON_END_DEF,
    parameter int unsigned STEP_PERIODS = 4,
    parameter int unsigned CW           = 21,
    localparam int unsigned IW = (N_LED > 1) ? $clog2(N_LED) : 1
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             Cmd_Valid,
    input  logic [1:0]       Cmd_Code,
    output logic             Cmd_Ready,
    output logic [N_LED-1:0] LED_Out,
    output logic [IW-1:0]    Active_Idx,
    output logic             Busy,
    output logic             Step_Done
);

    localparam int unsigned RW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [IW-1:0] C_IDX_LAST = IW'(N_LED - 1);
    localparam logic [RW-1:0] C_REP_LAST = RW'(STEP_PERIODS - 1);

    led_state_e    state_q, state_d;
    logic [RW-1:0] rep_q, rep_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          dir_q, dir_d;
    logic          pend_q, pend_d;
    logic [1:0]    pcode_q, pcode_d;
    logic          step_q, step_d;
    logic          busy_q;
    logic          w_accept, w_boundary, w_win;

    led_period_timer #(
        .PERIOD   (PERIOD),
        .ON_START (ON_START),
        .ON_END   (ON_END),
        .CW       (CW)
    ) u_timer (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .En_i       (state_q != ST_IDLE),
        .Clr_i      (state_q == ST_IDLE),
        .Boundary_o (w_boundary),
        .Win_o      (w_win)
    );

    assign Cmd_Ready  = !pend_q;
    assign w_accept   = Cmd_Valid && !pend_q;
    assign Active_Idx = idx_q;
    assign Busy       = busy_q;
    assign Step_Done  = step_q;

    always_comb begin
        state_d = state_q;
        rep_d   = rep_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        pcode_d = pcode_q;
        step_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            rep_d = '0;
            idx_d = '0;
            dir_d = 1'b1;
            if (w_accept && (Cmd_Code != CMD_STOP))
                state_d = code2state(Cmd_Code);
        end else begin
            if (w_boundary) begin
                if (pend_q) begin
                    state_d = code2state(pcode_q);
                    rep_d   = '0;
                    idx_d   = '0;
                    dir_d   = 1'b1;
                    pend_d  = 1'b0;
                end else if (rep_q != C_REP_LAST) begin
                    rep_d = rep_q + 1'b1;
                end else begin
                    rep_d  = '0;
                    step_d = 1'b1;
                    case (state_q)
                        ST_FWD: idx_d = (idx_q == C_IDX_LAST) ? '0 : idx_q + 1'b1;
                        ST_PP: begin
                            // Ends are visited once: turn around without repeating them.
                            if (N_LED == 1) begin
                                idx_d = '0;
                            end else if (dir_q) begin
                                if (idx_q == C_IDX_LAST) begin
                                    idx_d = idx_q - 1'b1;
                                    dir_d = 1'b0;
                                end else begin
                                    idx_d = idx_q + 1'b1;
                                end
                            end else begin
                                if (idx_q == '0) begin
                                    idx_d = idx_q + 1'b1;
                                    dir_d = 1'b1;
                                end else begin
                                    idx_d = idx_q - 1'b1;
                                end
                            end
                        end
                        default: idx_d = idx_q;
                    endcase
                end
            end
            // Only reachable with nothing pending, so a boundary-cycle command waits a full period.
            if (w_accept) begin
                pend_d  = 1'b1;
                pcode_d = Cmd_Code;
            end
        end
    end

    always_comb begin
        LED_Out = '0;
        for (int i = 0; i < N_LED; i++) begin
            LED_Out[i] = w_win && ((state_q == ST_BLINK) ||
                         (((state_q == ST_FWD) || (state_q == ST_PP)) && (idx_q == IW'(i))));
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            rep_q   <= '0;
            idx_q   <= '0;
            dir_q   <= 1'b1;
            pend_q  <= 1'b0;
            pcode_q <= CMD_STOP;
            step_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            pcode_q <= pcode_d;
            step_q  <= step_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_led_scan_ctrl : directed and random checks of led_scan_ctrl     |
// |                    against a period/step arithmetic model.         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_led_scan_ctrl;

    localparam int N    = 4;
    localparam int P    = 19;
    localparam int PLEN = P + 1;
    localparam int ONS  = 5;
    localparam int ONE  = 10;
    localparam int STEP = 2;
    localparam int CW   = 5;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       Cmd_Valid = 1'b0;
    logic [1:0] Cmd_Code = 2'b00;
    logic       Cmd_Ready;
    logic [3:0] LED_Out;
    logic [1:0] Active_Idx;
    logic       Busy;
    logic       Step_Done;

    led_scan_ctrl #(
        .N_LED(N), .PERIOD(P), .ON_START(ONS), .ON_END(ONE),
        .STEP_PERIODS(STEP), .CW(CW)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .Cmd_Valid(Cmd_Valid), .Cmd_Code(Cmd_Code),
        .Cmd_Ready(Cmd_Ready), .LED_Out(LED_Out), .Active_Idx(Active_Idx),
        .Busy(Busy), .Step_Done(Step_Done)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: mode (0 idle,1 fwd,2 pp,3 blink), cycles since run start, pending command.
    int         m_mode  = 0;
    int         m_pos   = 0;
    int         m_pcode = 0;
    bit         m_pend  = 1'b0;
    logic [3:0] e_led   = 4'h0;
    logic       e_step  = 1'b0;

    function automatic int idx_of(input int mode, input int pos);
        int s;
        int k;
        s = (pos / PLEN) / STEP;
        if (mode == 1) return s % N;
        if (mode == 2) begin
            k = s % (2 * N - 2);
            return (k < N) ? k : (2 * N - 2 - k);
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        chk("led",   32'(LED_Out),    32'(e_led));
        chk("idx",   32'(Active_Idx), 32'(idx_of(m_mode, m_pos)));
        chk("ready", 32'(Cmd_Ready),  32'(!m_pend));
        chk("busy",  32'(Busy),       32'(m_mode != 0));
        chk("step",  32'(Step_Done),  32'(e_step));
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_pend = 1'b0; m_pcode = 0;
        e_led = 4'h0; e_step = 1'b0;
    endtask

    task automatic tick(input bit v, input logic [1:0] code, output bit acc);
        int ph;
        logic [3:0] led_n;
        logic step_n;
        Cmd_Valid = v;
        Cmd_Code  = code;
        acc = v && !m_pend;
        ph = m_pos % PLEN;
        led_n = 4'h0;
        if (m_mode != 0 && ph >= ONS && ph < ONE)
            led_n = (m_mode == 3) ? 4'hF : 4'(1 << idx_of(m_mode, m_pos));
        step_n = (m_mode != 0) && (ph == P) && !m_pend && (((m_pos / PLEN) % STEP) == STEP - 1);
        @(posedge CLK);
        if (m_mode == 0) begin
            if (acc && code != 2'b00) begin
                m_mode = int'(code);
                m_pos  = 0;
            end
        end else begin
            if (ph == P && m_pend) begin
                m_mode = m_pcode;
                m_pos  = 0;
                m_pend = 1'b0;
            end else begin
                m_pos++;
            end
            if (acc) begin
                m_pend  = 1'b1;
                m_pcode = int'(code);
            end
        end
        e_led  = led_n;
        e_step = step_n;
        cyc++;
        #1 Cmd_Valid = 1'b0;
        @(negedge CLK);
        check_all();
    endtask

    task automatic run_to(input int n);
        bit a;
        while (cyc < n) tick(1'b0, 2'b00, a);
    endtask

    task automatic start(input logic [1:0] code);
        bit a;
        tick(1'b1, code, a);
        chk("start_accept", 32'(a), 32'd1);
        cyc = 1;
    endtask

    task automatic async_reset();
        #2 RSTn = 1'b0;
        #1;
        chk("rst_led",   32'(LED_Out),   32'd0);
        chk("rst_busy",  32'(Busy),      32'd0);
        chk("rst_ready", 32'(Cmd_Ready), 32'd1);
        model_reset();
        @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        check_all();
    endtask

    task automatic stop_and_wait();
        bit a;
        int k;
        tick(1'b1, 2'b00, a);
        k = 0;
        while (Busy && k < 100) begin
            tick(1'b0, 2'b00, a);
            k++;
        end
        chk("stop_idle", 32'(Busy), 32'd0);
    endtask

    initial begin
        int pp_seq [8];
        int base;
        int k;
        bit a;
        pp_seq = '{0, 1, 2, 3, 2, 1, 0, 1};

        repeat (3) @(negedge CLK);
        check_all();
        RSTn = 1'b1;
        @(negedge CLK);
        check_all();

        // Forward scan timing and wrap
        start(2'b01);
        run_to(7);   chk("fwd_c7",    32'(LED_Out),    32'h1);
        run_to(11);  chk("fwd_c11",   32'(LED_Out),    32'h1);
        run_to(12);  chk("fwd_c12",   32'(LED_Out),    32'h0);
        run_to(27);  chk("fwd_c27",   32'(LED_Out),    32'h1);
        run_to(41);  chk("fwd_step",  32'(Step_Done),  32'd1);
        run_to(47);  chk("fwd_c47",   32'(LED_Out),    32'h2);
        run_to(160); chk("fwd_idx3",  32'(Active_Idx), 32'd3);
        run_to(161); chk("fwd_wrap",  32'(Active_Idx), 32'd0);

        // STOP accepted at period cycle 8
        base = 160;
        run_to(base + 8);
        tick(1'b1, 2'b00, a);
        chk("stop_acc", 32'(a), 32'd1);
        run_to(base + 20); chk("stop_ready20", 32'(Cmd_Ready), 32'd0);
        chk("stop_busy20", 32'(Busy), 32'd1);
        run_to(base + 21); chk("stop_idle21", 32'(Busy), 32'd0);
        chk("stop_ready21", 32'(Cmd_Ready), 32'd1);
        run_to(base + 30); chk("stop_led", 32'(LED_Out), 32'h0);

        // Reset asserted mid-window
        start(2'b01);
        run_to(9);
        chk("pre_rst_led", 32'(LED_Out), 32'h1);
        async_reset();

        // Ping-pong over 16 periods
        start(2'b10);
        for (int j = 0; j < 8; j++) begin
            run_to(40 * j + 5);
            chk("pp_seq", 32'(Active_Idx), 32'(pp_seq[j]));
        end
        stop_and_wait();

        // Blink-all, then a command issued on the boundary
        start(2'b11);
        run_to(7);  chk("blink_c7",   32'(LED_Out),    32'hF);
        chk("blink_idx", 32'(Active_Idx), 32'd0);
        run_to(20);
        tick(1'b1, 2'b01, a);
        chk("bnd_acc", 32'(a), 32'd1);
        k = 0;
        a = 1'b0;
        while (!a && k < 60) begin
            tick(1'b1, 2'b10, a);
            k++;
        end
        chk("stall_release", 32'(cyc), 32'd42);
        run_to(47); chk("bnd_fwd_led", 32'(LED_Out), 32'h1);
        run_to(67); chk("bnd_pp_led",  32'(LED_Out), 32'h1);
        stop_and_wait();

        // Random command traffic with occasional reset
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
            end else begin
                tick($urandom_range(0, 24) == 0, 2'($urandom_range(0, 3)), a);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
